// File: rtl/spread_frame_sched.sv
// rtl/spread_frame_sched.sv - round-robin frame scheduler feeding a bit-serial spreader
//
// Shares one bit-serial spreader among N_REQ byte-stream requesters. The
// round-robin winner holds the spreader for a whole frame:
// SYNC_WORD, requester ID (ID_W bits), FRAME_BYTES payload bytes, all MSB first.
//
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_req             per-requester frame request
//   o_gnt             one-hot grant, held for the whole frame
//   i_byte            payload bytes, requester k on [8k+7:8k]
//   i_byte_valid      per-requester byte valid
//   o_byte_ready      per-requester byte ready (granted lane only)
//   i_spr_ready       spreader ready to take a bit
//   o_spr_data        bit to the spreader
//   o_spr_valid       one-cycle strobe, bit accepted
//   o_active_id       index of the granted requester
//   o_busy            high from ARB through DONE
//   o_frame_done      one-cycle pulse at end of frame
module spread_frame_sched #(
  parameter int         N_REQ       = 4,
  parameter int         FRAME_BYTES = 8,
  parameter logic [7:0] SYNC_WORD   = 8'hA5,
  parameter int         ID_W        = $clog2(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [N_REQ-1:0]   i_req,
  output logic [N_REQ-1:0]   o_gnt,
  input  logic [8*N_REQ-1:0] i_byte,
  input  logic [N_REQ-1:0]   i_byte_valid,
  output logic [N_REQ-1:0]   o_byte_ready,
  input  logic               i_spr_ready,
  output logic               o_spr_data,
  output logic               o_spr_valid,
  output logic [ID_W-1:0]    o_active_id,
  output logic               o_busy,
  output logic               o_frame_done
);

  localparam int BC_W = $clog2(FRAME_BYTES + 1);
  localparam logic [BC_W-1:0] LAST_CNT = BC_W'(FRAME_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_SYNC, S_ID, S_LOAD, S_BITS, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [7:0]        sr_q, sr_d;        // MSB is the bit currently offered
  logic [2:0]        bit_q, bit_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic              valid_q, valid_d;
  logic              data_q, data_d;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic              shifting;
  logic              last_bit;
  logic [7:0]        sel_byte;
  logic              sel_valid;

  // Round-robin search starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!win_found && i_req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign sel_byte  = i_byte[int'(id_q)*8 +: 8];
  assign sel_valid = i_byte_valid[id_q];
  assign shifting  = (state_q == S_SYNC) || (state_q == S_ID) || (state_q == S_BITS);

  always_comb begin
    last_bit = 1'b0;
    case (state_q)
      S_SYNC:  last_bit = (bit_q == 3'd7);
      S_ID:    last_bit = (bit_q == 3'(ID_W - 1));
      S_BITS:  last_bit = (bit_q == 3'd7);
      default: last_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    gnt_d      = gnt_q;
    sr_d       = sr_q;
    bit_d      = bit_q;
    byte_cnt_d = byte_cnt_q;
    // A strobe can only follow a non-strobe cycle, so bits go out at most
    // every other cycle and the bit position only moves on a strobe.
    valid_d    = shifting && i_spr_ready && !valid_q;
    data_d     = valid_d ? sr_q[7] : 1'b0;

    if (shifting && valid_q) begin
      sr_d  = {sr_q[6:0], 1'b0};
      bit_d = bit_q + 3'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (|i_req) state_d = S_ARB;
      end
      S_ARB: begin
        if (win_found) begin
          id_d       = win_id;
          gnt_d      = N_REQ'(1) << win_id;
          sr_d       = SYNC_WORD;
          bit_d      = '0;
          byte_cnt_d = '0;
          state_d    = S_SYNC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SYNC: begin
        if (valid_q && last_bit) begin
          // ID field left-aligned so it also leaves from sr_q[7].
          sr_d    = 8'(id_q) << (8 - ID_W);
          bit_d   = '0;
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (valid_q && last_bit) begin
          bit_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (sel_valid) begin
          sr_d       = sel_byte;
          bit_d      = '0;
          byte_cnt_d = byte_cnt_q + BC_W'(1);
          state_d    = S_BITS;
        end
      end
      S_BITS: begin
        if (valid_q && last_bit) begin
          bit_d = '0;
          if (byte_cnt_q < LAST_CNT) begin
            state_d = S_LOAD;
          end else begin
            gnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      gnt_q      <= '0;
      sr_q       <= '0;
      bit_q      <= '0;
      byte_cnt_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      gnt_q      <= gnt_d;
      sr_q       <= sr_d;
      bit_q      <= bit_d;
      byte_cnt_q <= byte_cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  assign o_gnt        = gnt_q;
  assign o_byte_ready = (state_q == S_LOAD) ? gnt_q : '0;
  assign o_spr_data   = data_q;
  assign o_spr_valid  = valid_q;
  assign o_active_id  = id_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = (state_q == S_DONE);

endmodule

// File: doc/spread_frame_sched.md
Name: spread_frame_sched

Overview:
- Frame scheduler in front of the Spread block: shares one bit-serial spreader among N_REQ byte-stream requesters.
- Round-robin arbitration between requesters; the winner holds the spreader for one whole frame.
- Frame format on the spreader input: SYNC_WORD, then the requester ID, then FRAME_BYTES payload bytes, all MSB first.
- Drives the spreader's single-bit data/valid input, paced by the spreader's ready output.

Parameters:
N_REQ, 4, number of requesters (>=2)
FRAME_BYTES, 8, payload bytes per frame (>=1)
SYNC_WORD, 8'hA5, 8-bit sync pattern sent first in every frame
ID_W, $clog2(N_REQ), width of the requester ID field

Ports:
i_clk  in  1  clock; only clock domain
i_reset  in  1  synchronous, active-high reset
i_req  in  N_REQ  per-requester frame request
o_gnt  out  N_REQ  one-hot grant, held for the whole frame
i_byte  in  8*N_REQ  payload bytes; requester k uses bits [8k+7:8k]
i_byte_valid  in  N_REQ  per-requester byte valid
o_byte_ready  out  N_REQ  per-requester byte ready; only the granted bit may be 1
i_spr_ready  in  1  spreader ready to take one bit
o_spr_data  out  1  bit to the spreader
o_spr_valid  out  1  one-cycle strobe: bit accepted
o_active_id  out  ID_W  index of the granted requester
o_busy  out  1  high from ARB until DONE inclusive
o_frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (synchronous, any state, including mid-frame):
  - all outputs 0;
  - round-robin pointer 0;
  - state IDLE;
  - any partial frame is dropped.
- States: IDLE -> ARB -> SYNC -> ID -> LOAD -> BITS -> (LOAD | DONE) -> IDLE.
- IDLE: go to ARB when |i_req is high.
- ARB (1 cycle):
  - search i_req from the pointer upward, wrapping modulo N_REQ;
  - first set bit k wins: o_gnt=1<<k, o_active_id=k;
  - if i_req has gone to 0, return to IDLE.
- SYNC: shift out the 8 SYNC_WORD bits, MSB first.
- ID: shift out the ID_W bits of k, MSB first.
- LOAD:
  - o_byte_ready[k]=1; byte is taken on the cycle where i_byte_valid[k]=1;
  - ready drops the next cycle; go to BITS;
  - with no valid, wait indefinitely; no bits are sent, spreader stays idle.
- BITS: shift out the 8 byte bits, MSB first.
  - After the last bit: if bytes sent < FRAME_BYTES go to LOAD, else go to DONE.
- DONE (1 cycle):
  - o_frame_done=1; o_gnt cleared; pointer <= k+1 (wraps to 0 at N_REQ).
  - Next cycle is IDLE.
- Bit handshake (SYNC/ID/BITS):
  - o_spr_valid is registered: set for exactly one cycle when i_spr_ready was 1 in the previous cycle and o_spr_valid was 0;
  - never high in two consecutive cycles;
  - o_spr_data holds the current bit while o_spr_valid is high;
  - bit counter advances on each o_spr_valid.
- i_spr_ready low: state and bit position are held indefinitely.
- Requester drops i_req mid-frame: ignored; the frame completes with the same grant.
- Bits per frame: 8 + ID_W + 8*FRAME_BYTES.
- Byte counter width: $clog2(FRAME_BYTES+1).
- o_byte_ready and i_byte_valid of non-granted requesters: ready stays 0, valid is ignored.
- Simultaneous new request in DONE: not evaluated until the following ARB, so there is no grant gap shortcut.

Test Plan:
- Reset, then req=4'b0001, bytes 8'hC3,8'h5A (FRAME_BYTES=2), spreader model always re-ready 1 cycle after accept -> 26 bits: 10100101, 00, 11000011, 01011010; o_frame_done one pulse; o_gnt=0001 throughout.
- req=4'b0101 held constant for 3 frames -> grant order 0,2,0; o_active_id 0,2,0; ID bits 00,10,00.
- Grant 3, then req=4'b1001 -> next grant 0 (pointer wrap); ID field 11 then 00.
- i_byte_valid[k] low for 20 cycles in LOAD -> no o_spr_valid pulses, o_byte_ready[k] stays 1; frame resumes cleanly when valid asserts.
- i_spr_ready held low 15 cycles mid-BITS, and separately held high constantly -> no bit lost or duplicated; o_spr_valid never high on 2 consecutive cycles.
- i_reset pulsed during the ID state -> next cycle all outputs 0, pointer 0; a new request restarts a full frame beginning with SYNC_WORD.
